// File: rtl/axis_video_pkg.sv
// axis_video_pkg: shared types and constants for the AXI4-Stream video receive path
package axis_video_pkg;

    typedef enum logic [1:0] {WAIT_SOF, ACTIVE} rx_state_t;

    localparam int FRAME_CNT_W = 16;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } pix_flags_t;

endpackage

// File: rtl/video_xy_counter.sv
// video_xy_counter: raster x/y position tracker with WIDTH/HEIGHT wrap.
// clear rebases the current beat to (0,0) before step/line_end apply,
// so a start-of-frame beat both restarts and advances the raster.
module video_xy_counter #(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 10,
    localparam int XW    = $clog2(WIDTH),
    localparam int YW    = $clog2(HEIGHT)
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          step,
    input  logic          line_end,
    input  logic          clear,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last_x,
    output logic          last_y
);

    logic [XW-1:0] x_q, x_d, bx;
    logic [YW-1:0] y_q, y_d, by;

    // next position: optional rebase to origin, then advance or wrap to the next line
    always_comb begin
        bx  = clear ? '0 : x_q;
        by  = clear ? '0 : y_q;
        x_d = step ? (line_end ? '0 : XW'(bx + XW'(1))) : bx;
        y_d = (step && line_end) ? ((by == YW'(HEIGHT - 1)) ? '0 : YW'(by + YW'(1))) : by;
    end

    // position registers
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign last_x = (x_q == XW'(WIDTH - 1));
    assign last_y = (y_q == YW'(HEIGHT - 1));

endmodule

// File: rtl/axis_video_rx.sv
// axis_video_rx: AXI4-Stream video sink that locks to tuser, tags pixels with (x,y)
// and SOF/EOL/EOF, and flags framing errors. Optional statistics outputs are
// enabled by defining AXIS_VIDEO_RX_STATS_EN.
module axis_video_rx
    import axis_video_pkg::*;
#(
    parameter int N       = 8,
    parameter int WIDTH   = 10,
    parameter int HEIGHT  = 10,
    localparam int XW     = $clog2(WIDTH),
    localparam int YW     = $clog2(HEIGHT)
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [N-1:0]           s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tuser,
    input  logic                   s_axis_tlast,
    output logic [N-1:0]           pix_data,
    output logic                   pix_valid,
    output logic [XW-1:0]          pix_x,
    output logic [YW-1:0]          pix_y,
    output logic                   pix_sof,
    output logic                   pix_eol,
    output logic                   pix_eof,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
`ifdef AXIS_VIDEO_RX_STATS_EN
    output logic [15:0]            stat_err_cnt,
    output logic [XW:0]            stat_line_len,
`endif
    output logic                   err_early_tlast,
    output logic                   err_missing_tlast,
    output logic                   err_early_sof,
    output logic                   err_no_sof
);

    rx_state_t              state_q, state_d;
    logic                   tready_q;
    logic [N-1:0]           pix_data_q, pix_data_d;
    logic                   pix_valid_q, pix_valid_d;
    logic [XW-1:0]          pix_x_q, pix_x_d;
    logic [YW-1:0]          pix_y_q, pix_y_d;
    pix_flags_t             flags_q, flags_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]             err_q, err_d;

    logic          xfer, sof_beat, emit, eol, eof;
    logic [XW-1:0] x, ex;
    logic [YW-1:0] y, ey;
    logic          last_x, last_y;

    // A tuser beat is always pixel (0,0), whatever the counters currently hold.
    assign xfer     = s_axis_tvalid & tready_q;
    assign sof_beat = xfer & s_axis_tuser;
    assign emit     = xfer & ((state_q == ACTIVE) | s_axis_tuser);
    assign ex       = sof_beat ? '0 : x;
    assign ey       = sof_beat ? '0 : y;
    assign eol      = emit & (s_axis_tlast | (~s_axis_tuser & last_x));
    assign eof      = eol & ~s_axis_tuser & last_y;

    video_xy_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_xy (
        .clk      (clk),
        .aresetn  (aresetn),
        .step     (emit),
        .line_end (eol),
        .clear    (sof_beat),
        .x        (x),
        .y        (y),
        .last_x   (last_x),
        .last_y   (last_y)
    );

    // state register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state_q <= WAIT_SOF;
        else          state_q <= state_d;
    end

    // next state: lock on tuser, drop lock once a frame completes
    always_comb begin
        state_d = eof ? WAIT_SOF : (sof_beat ? ACTIVE : state_q);
    end

    // output decode: pixel tagging, framing errors and frame count
    always_comb begin
        pix_valid_d = emit;
        pix_data_d  = emit ? s_axis_tdata : pix_data_q;
        pix_x_d     = emit ? ex : pix_x_q;
        pix_y_d     = emit ? ey : pix_y_q;
        flags_d     = '{sof: sof_beat, eol: eol, eof: eof};
        err_d[3]    = emit & s_axis_tlast & (s_axis_tuser | ~last_x);
        err_d[2]    = emit & ~s_axis_tuser & last_x & ~s_axis_tlast;
        err_d[1]    = sof_beat & (state_q == ACTIVE);
        err_d[0]    = xfer & (state_q == WAIT_SOF) & ~s_axis_tuser;
        frame_cnt_d = eof ? frame_cnt_q + FRAME_CNT_W'(1) : frame_cnt_q;
    end

    // output registers
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            tready_q    <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            flags_q     <= '0;
            frame_cnt_q <= '0;
            err_q       <= '0;
        end else begin
            tready_q    <= 1'b1;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            flags_q     <= flags_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    assign s_axis_tready     = tready_q;
    assign pix_data          = pix_data_q;
    assign pix_valid         = pix_valid_q;
    assign pix_x             = pix_x_q;
    assign pix_y             = pix_y_q;
    assign pix_sof           = flags_q.sof;
    assign pix_eol           = flags_q.eol;
    assign pix_eof           = flags_q.eof;
    assign frame_cnt         = frame_cnt_q;
    assign err_early_tlast   = err_q[3];
    assign err_missing_tlast = err_q[2];
    assign err_early_sof     = err_q[1];
    assign err_no_sof        = err_q[0];

`ifdef AXIS_VIDEO_RX_STATS_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [XW:0] line_len_q, line_len_d;
    logic [16:0] err_sum;

    // saturating error total and length of the most recent completed line
    always_comb begin
        err_sum    = {1'b0, err_cnt_q} + 17'(err_d[3]) + 17'(err_d[2]) + 17'(err_d[1]) + 17'(err_d[0]);
        err_cnt_d  = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        line_len_d = eol ? ({1'b0, ex} + (XW+1)'(1)) : line_len_q;
    end

    // statistics registers
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            err_cnt_q  <= '0;
            line_len_q <= '0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            line_len_q <= line_len_d;
        end
    end

    assign stat_err_cnt  = err_cnt_q;
    assign stat_line_len = line_len_q;
`endif

endmodule

// File: tb/tb_axis_video_rx.sv
// tb_axis_video_rx: directed self-checking bench for axis_video_rx (10x10 frames)
module tb_axis_video_rx;

    localparam int N = 8, W = 10, H = 10, XW = 4, YW = 4;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [N-1:0]  s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tuser = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic [N-1:0]  pix_data;
    logic          pix_valid;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_sof, pix_eol, pix_eof;
    logic [15:0]   frame_cnt;
    logic          err_early_tlast, err_missing_tlast, err_early_sof, err_no_sof;
`ifdef AXIS_VIDEO_RX_STATS_EN
    logic [15:0]   stat_err_cnt;
    logic [XW:0]   stat_line_len;
`endif

    int n_chk = 0, n_pass = 0;

    axis_video_rx #(.N(N), .WIDTH(W), .HEIGHT(H)) dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tuser      (s_axis_tuser),
        .s_axis_tlast      (s_axis_tlast),
        .pix_data          (pix_data),
        .pix_valid         (pix_valid),
        .pix_x             (pix_x),
        .pix_y             (pix_y),
        .pix_sof           (pix_sof),
        .pix_eol           (pix_eol),
        .pix_eof           (pix_eof),
        .frame_cnt         (frame_cnt),
`ifdef AXIS_VIDEO_RX_STATS_EN
        .stat_err_cnt      (stat_err_cnt),
        .stat_line_len     (stat_line_len),
`endif
        .err_early_tlast   (err_early_tlast),
        .err_missing_tlast (err_missing_tlast),
        .err_early_sof     (err_early_sof),
        .err_no_sof        (err_no_sof)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // {valid, data, x, y, sof, eol, eof, errs}; data/x/y only compared on valid pixels
    function automatic logic [31:0] pack(input logic v, input logic [7:0] d, input int x, input int y,
                                         input logic sof, input logic eol, input logic eof,
                                         input logic [3:0] er);
        return {8'h0, v, v ? d : 8'h0, v ? 4'(x) : 4'h0, v ? 4'(y) : 4'h0, sof, eol, eof, er};
    endfunction

    function automatic logic [31:0] obs();
        return pack(pix_valid, pix_data, int'(pix_x), int'(pix_y), pix_sof, pix_eol, pix_eof,
                    {err_early_tlast, err_missing_tlast, err_early_sof, err_no_sof});
    endfunction

    function automatic logic [7:0] dat(input int x, input int y);
        return 8'(x + 10 * y + 1);
    endfunction

    task automatic beat(input string tag, input logic [7:0] d, input bit u, input bit l,
                        input bit v, input int ex, input int ey,
                        input bit sof, input bit eol, input bit eof, input logic [3:0] er);
        @(negedge clk);
        s_axis_tdata = d; s_axis_tvalid = 1'b1; s_axis_tuser = u; s_axis_tlast = l;
        @(posedge clk); #1;
        check(tag, obs(), pack(v, d, ex, ey, sof, eol, eof, er));
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
        repeat (n) @(posedge clk);
        #1 check("gap_no_pix", {31'h0, pix_valid}, 32'h0);
    endtask

    // well-formed frame from (x0,y0); optional gap at (2,0), line and frame pauses
    task automatic run_lines(input int y0, input int x0, input int gap_line, input bit gap_mid);
        for (int y = y0; y < H; y++) begin
            for (int x = (y == y0) ? x0 : 0; x < W; x++) begin
                beat("pix", dat(x, y), x == 0 && y == 0, x == W - 1, 1'b1, x, y,
                     x == 0 && y == 0, x == W - 1, x == W - 1 && y == H - 1, 4'b0000);
                if (gap_mid && x == 1 && y == 0) idle(1);
            end
            if (gap_line > 0) idle(y == H - 1 ? 10 : gap_line);
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", {31'h0, s_axis_tready}, 32'h0);
        check("rst_pix", obs(), 32'h0);
        check("rst_frame_cnt", {16'h0, frame_cnt}, 32'h0);
        @(negedge clk) aresetn = 1'b1;
        @(posedge clk); #1;
        check("tready_after_rst", {31'h0, s_axis_tready}, 32'h1);

        // clean frame, continuous
        run_lines(0, 0, 0, 1'b0);
        idle(1);
        check("frame_cnt_clean", {16'h0, frame_cnt}, 32'd1);
`ifdef AXIS_VIDEO_RX_STATS_EN
        check("stat_line_len", {27'h0, stat_line_len}, 32'd10);
        check("stat_err_clean", {16'h0, stat_err_cnt}, 32'd0);
`endif

        // five frames with gaps and pauses
        for (int f = 0; f < 5; f++) run_lines(0, 0, 4, 1'b1);
        check("frame_cnt_gaps", {16'h0, frame_cnt}, 32'd6);

        // framing errors: early tlast line 0, missing tlast line 1, early tlast on last line
        for (int x = 0; x < 8; x++)
            beat("early_tlast_l0", dat(x, 0), x == 0, x == 7, 1'b1, x, 0, x == 0, x == 7, 1'b0,
                 x == 7 ? 4'b1000 : 4'b0000);
        for (int x = 0; x < W; x++)
            beat("missing_tlast_l1", dat(x, 1), 1'b0, 1'b0, 1'b1, x, 1, 1'b0, x == W - 1, 1'b0,
                 x == W - 1 ? 4'b0100 : 4'b0000);
        for (int y = 2; y < H - 1; y++)
            for (int x = 0; x < W; x++)
                beat("err_frame_mid", dat(x, y), 1'b0, x == W - 1, 1'b1, x, y, 1'b0, x == W - 1, 1'b0, 4'b0000);
        for (int x = 0; x < 4; x++)
            beat("early_tlast_last", dat(x, 9), 1'b0, x == 3, 1'b1, x, 9, 1'b0, x == 3, x == 3,
                 x == 3 ? 4'b1000 : 4'b0000);
        check("frame_cnt_err", {16'h0, frame_cnt}, 32'd7);

        // beats before tuser are discarded; pixel outputs hold
        for (int i = 0; i < 3; i++)
            beat("no_sof", 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 4'b0001);
        check("hold_x", {28'h0, pix_x}, 32'd3);
        check("hold_data", {24'h0, pix_data}, {24'h0, dat(3, 9)});

        // early tuser at (4,3) restarts the frame without counting it
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < W && !(y == 3 && x == 4); x++)
                beat("pre_early_sof", dat(x, y), x == 0 && y == 0, x == W - 1, 1'b1, x, y,
                     x == 0 && y == 0, x == W - 1, 1'b0, 4'b0000);
        beat("early_sof", 8'h55, 1'b1, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 4'b0010);
        check("frame_cnt_early_sof", {16'h0, frame_cnt}, 32'd7);
        run_lines(0, 1, 0, 1'b0);
        check("frame_cnt_after_resync", {16'h0, frame_cnt}, 32'd8);

        // tuser and tlast together while waiting: one-pixel line
        beat("sof_tlast", 8'h77, 1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 4'b1000);
        beat("after_sof_tlast", 8'h78, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0, 4'b0000);
`ifdef AXIS_VIDEO_RX_STATS_EN
        check("stat_err_total", {16'h0, stat_err_cnt}, 32'd8);
        check("stat_line_len_one", {27'h0, stat_line_len}, 32'd1);
`endif

        // asynchronous reset mid-frame
        @(negedge clk);
        s_axis_tvalid = 1'b0; aresetn = 1'b0;
        #2;
        check("midrst_tready", {31'h0, s_axis_tready}, 32'h0);
        check("midrst_frame_cnt", {16'h0, frame_cnt}, 32'h0);
        check("midrst_pix", obs(), 32'h0);
        @(negedge clk) aresetn = 1'b1;
        @(posedge clk); #1;
        beat("post_rst_no_sof", 8'h11, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 4'b0001);
        beat("post_rst_sof", 8'h12, 1'b1, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 4'b0000);
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
